// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory and decode-handshake bundle of the fetch unit
interface instr_fetch_unit_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [5:0]  op_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  modport master (
    output imem_addr_o, instr_o, pc_o, op_o, valid_o,
    input  imem_data_i, ready_i, redirect_i, redirect_pc_i
  );
  modport slave (
    input  imem_addr_o, instr_o, pc_o, op_o, valid_o,
    output imem_data_i, ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch buffer feeding decode over a valid/ready handshake
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic clk_i,
  input logic rst_i,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [31:0] pcs_q [DEPTH];
  logic [31:0] pcs_d [DEPTH];
  logic [31:0] ins_q [DEPTH];
  logic [31:0] ins_d [DEPTH];
  logic [31:0] instr;
  logic pop, push, valid;
  always_comb begin
    valid = cnt_q != '0;
    pop = valid & bus.ready_i;
    push = ~bus.redirect_i & ((cnt_q < FULL) | pop);
    pcs_d = pcs_q;
    ins_d = ins_q;
    if (push) begin
      pcs_d[wr_q] = pc_q;
      ins_d[wr_q] = bus.imem_data_i;
    end
    // redirect flushes everything; a concurrent pop is irrelevant once the buffer is cleared
    rd_d = bus.redirect_i ? '0 : rd_q + PW'(pop);
    wr_d = bus.redirect_i ? '0 : wr_q + PW'(push);
    cnt_d = bus.redirect_i ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    pc_d = bus.redirect_i ? (bus.redirect_pc_i & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
    pcs_q <= pcs_d;
    ins_q <= ins_d;
  end
  assign instr = valid ? ins_q[rd_q] : '0;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o = valid;
  assign bus.instr_o = instr;
  assign bus.pc_o = valid ? pcs_q[rd_q] : '0;
  assign bus.op_o = instr[31:26];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch traffic checked against a queue-based reference model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  instr_fetch_unit_if ifc ();
  instr_fetch_unit_if ifw ();
  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifc.master)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk_i(clk), .rst_i(rst), .bus(ifw.master)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h2008_0005 : a == 32'h4 ? 32'h2009_0003 : (a * 32'h9E37_79B1) ^ 32'h0C00_1234;
  endfunction
  assign ifc.imem_data_i = mem(ifc.imem_addr_o);
  assign ifw.imem_data_i = mem(ifw.imem_addr_o);
  assign ifw.ready_i = 1'b1;
  assign ifw.redirect_i = 1'b0;
  assign ifw.redirect_pc_i = 32'h0;
  logic [31:0] mpc [$];
  logic [31:0] mins [$];
  logic [31:0] m_pc = 32'h0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    bit pop, push;
    rst = r;
    ifc.ready_i = rdy;
    ifc.redirect_i = rd;
    ifc.redirect_pc_i = rpc;
    #1;
    if (r) begin
      mpc.delete(); mins.delete(); m_pc = 32'h0;
    end else if (rd) begin
      mpc.delete(); mins.delete(); m_pc = rpc & ~32'd3;
    end else begin
      pop = mpc.size() > 0 && rdy;
      push = mpc.size() < DEPTH || pop;
      if (pop) begin
        void'(mpc.pop_front());
        void'(mins.pop_front());
      end
      if (push) begin
        mpc.push_back(m_pc);
        mins.push_back(mem(m_pc));
        m_pc += 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid", 32'(ifc.valid_o), 32'(mpc.size() != 0));
    chk("instr", ifc.instr_o, mpc.size() != 0 ? mins[0] : 32'h0);
    chk("pc", ifc.pc_o, mpc.size() != 0 ? mpc[0] : 32'h0);
    chk("op", 32'(ifc.op_o), mpc.size() != 0 ? 32'(mins[0][31:26]) : 32'h0);
    chk("imem_addr", ifc.imem_addr_o, m_pc);
  endtask
  initial begin
    ifc.ready_i = 1'b0;
    ifc.redirect_i = 1'b0;
    ifc.redirect_pc_i = 32'h0;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("wrap_reset_addr", ifw.imem_addr_o, 32'hFFFF_FFF8);
    step(0, 1, 0, 0);
    chk("first_instr", ifc.instr_o, 32'h2008_0005);
    chk("first_op", 32'(ifc.op_o), 32'h08);
    chk("wrap_pc0", ifw.pc_o, 32'hFFFF_FFF8);
    step(0, 1, 0, 0);
    chk("second_pc", ifc.pc_o, 32'h4);
    chk("wrap_pc1", ifw.pc_o, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap_pc2", ifw.pc_o, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_addr", ifc.imem_addr_o, 32'h8);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("full_pop_addr", ifc.imem_addr_o, 32'hC);
    chk("full_pop_pc", ifc.pc_o, 32'h4);
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0043);
    chk("redir_valid", 32'(ifc.valid_o), 32'h0);
    chk("redir_addr", ifc.imem_addr_o, 32'h40);
    step(0, 1, 0, 0);
    chk("redir_pc", ifc.pc_o, 32'h40);
    step(0, 0, 1, 32'h0000_0200);
    step(0, 0, 1, 32'h0000_0300);
    step(0, 0, 0, 0);
    chk("last_redir_wins", ifc.pc_o, 32'h300);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0100);
    chk("rst_over_redir_valid", 32'(ifc.valid_o), 32'h0);
    chk("rst_over_redir_addr", ifc.imem_addr_o, 32'h0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 7) == 0, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
